// File: rtl/mux_n1_pipe.sv
// N-to-1 operand selector feeding a 2-entry skid buffer (main + skid) with valid/ready flow control.
// Out-of-range selects travel as a zero word flagged by out_err.
module mux_n1_pipe #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               out_err,
    output logic [1:0]         o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready and out_valid are decoded from registered state only, so no combinational
    // path exists from out_ready to in_ready.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_main_data;
    logic               r_main_err;
    logic [WIDTH-1:0]   r_skid_data;
    logic               r_skid_err;

    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_err;
    logic               w_in_xfer;
    logic               w_out_xfer;

    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) begin
                w_sel_data = d[i*WIDTH +: WIDTH];
                w_sel_err  = 1'b0;
            end
        end
    end

    assign in_ready    = (r_state != ST_FULL);
    assign out_valid   = (r_state != ST_EMPTY);
    assign y           = r_main_data;
    assign out_err     = r_main_err;
    assign o_dbg_state = r_state;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main_data <= w_sel_data;
                        r_main_err  <= w_sel_err;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main_data <= w_sel_data;
                        r_main_err  <= w_sel_err;
                    end else if (w_in_xfer) begin
                        r_skid_data <= w_sel_data;
                        r_skid_err  <= w_sel_err;
                        r_state     <= ST_FULL;
                    end else if (w_out_xfer) begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain of main can happen.
                    if (w_out_xfer) begin
                        r_main_data <= r_skid_data;
                        r_main_err  <= r_skid_err;
                        r_state     <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Self-checking bench for mux_n1_pipe: directed steps plus random stress against a queue model,
// with extra instances for out-of-range select and width/depth corners.
module tb_mux_n1_pipe;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: WIDTH=32, N=4
    logic         in_valid, in_ready, out_valid, out_ready, out_err;
    logic [1:0]   sel, dbg_state;
    logic [127:0] d;
    logic [31:0]  y;

    mux_n1_pipe #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_err(out_err), .o_dbg_state(dbg_state)
    );

    // N=3 instance for out-of-range select
    logic        iv3, ir3, ov3, or3, err3;
    logic [1:0]  sel3, st3;
    logic [95:0] d3;
    logic [31:0] y3;

    mux_n1_pipe #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .sel(sel3), .d(d3),
        .out_valid(ov3), .out_ready(or3), .y(y3), .out_err(err3), .o_dbg_state(st3)
    );

    // WIDTH=8, N=2 instance
    logic        iv2, ir2, ov2, or2, err2;
    logic        sel2;
    logic [1:0]  st2;
    logic [15:0] d2;
    logic [7:0]  y2;

    mux_n1_pipe #(.WIDTH(8), .N(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .sel(sel2), .d(d2),
        .out_valid(ov2), .out_ready(or2), .y(y2), .out_err(err2), .o_dbg_state(st2)
    );

    // WIDTH=64, N=8 instance
    logic         iv8, ir8, ov8, or8, err8;
    logic [2:0]   sel8;
    logic [1:0]   st8;
    logic [511:0] d8;
    logic [63:0]  y8;

    mux_n1_pipe #(.WIDTH(64), .N(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .sel(sel8), .d(d8),
        .out_valid(ov8), .out_ready(or8), .y(y8), .out_err(err8), .o_dbg_state(st8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pick: {err, word} for the main instance's N=4 / WIDTH=32 configuration.
    function automatic logic [32:0] ref_pick(input logic [127:0] dd, input int s);
        if (s >= 4) return {1'b1, 32'h0};
        return {1'b0, dd[s*32 +: 32]};
    endfunction

    // Scoreboard for the main instance: the queue holds every accepted result in order,
    // so its length is the number of stored entries.
    logic [32:0] exp_q[$];
    logic [32:0] exp_item;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            check("out_valid_vs_model", out_valid, exp_q.size() != 0);
            check("in_ready_vs_model", in_ready, exp_q.size() < 2);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                check("y_err_stream", {out_err, y}, exp_item);
            end
            if (in_valid && in_ready) exp_q.push_back(ref_pick(d, int'(sel)));
        end
    end

    logic [31:0] words [4];

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; sel = '0; d = '0;
        iv3 = 1'b0; or3 = 1'b1; sel3 = '0; d3 = '0;
        iv2 = 1'b0; or2 = 1'b1; sel2 = '0; d2 = '0;
        iv8 = 1'b0; or8 = 1'b1; sel8 = '0; d8 = '0;

        // reset state
        tick(); tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_y", y, 32'h0);
        check("rst_err", out_err, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        reset = 1'b0;

        // streaming with out_ready held high
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        d = {words[3], words[2], words[1], words[0]};
        out_ready = 1'b1;
        in_valid = 1'b1; sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_y", y, words[i]);
            check("stream_valid", out_valid, 1'b1);
            check("stream_in_ready", in_ready, 1'b1);
            sel = 2'(i + 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid, 1'b0);

        // backpressure fills the skid entry
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd1;
        tick();
        check("bp_y_first", y, 32'h22);
        check("bp_ready_one", in_ready, 1'b1);
        sel = 2'd2;
        tick();
        check("bp_full_state", dbg_state, 2'd2);
        check("bp_full_ready", in_ready, 1'b0);
        check("bp_hold_y", y, 32'h22);
        in_valid = 1'b0; sel = 2'd3; d = ~d;
        tick();
        check("bp_hold_y2", y, 32'h22);
        check("bp_hold_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        check("bp_next_y", y, 32'h33);
        check("bp_ready_back", in_ready, 1'b1);
        tick();
        check("bp_empty", out_valid, 1'b0);

        // asynchronous reset while full
        d = {words[3], words[2], words[1], words[0]};
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd3;
        tick();
        sel = 2'd0;
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", dbg_state, 2'd2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_ready", in_ready, 1'b1);
        check("async_rst_y", y, 32'h0);
        check("async_rst_state", dbg_state, 2'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_data", {out_valid, y}, 33'h0);
        end

        // random stress against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            d         = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        check("stress_drained", exp_q.size(), 0);

        // out-of-range select on N=3
        d3 = {32'hC, 32'hB, 32'hA};
        iv3 = 1'b1; sel3 = 2'd3;
        tick();
        check("oor_y", y3, 32'h0);
        check("oor_err", err3, 1'b1);
        check("oor_valid", ov3, 1'b1);
        sel3 = 2'd2;
        tick();
        check("after_oor_y", y3, 32'hC);
        check("after_oor_err", err3, 1'b0);
        iv3 = 1'b0; sel3 = 2'd0; d3 = '1;
        tick();
        check("idle_no_effect_valid", ov3, 1'b0);
        check("idle_no_effect_y", y3, 32'hC);

        // width/depth corners
        d2 = {8'hFF, 8'h5A};
        iv2 = 1'b1; sel2 = 1'b1;
        d8 = {64'hFFFF_FFFF_FFFF_FFFF, 448'h0};
        d8[63:0] = {$urandom, $urandom};
        iv8 = 1'b1; sel8 = 3'd7;
        tick();
        check("w8_all_ones", y2, 8'hFF);
        check("w64_all_ones", y8, 64'hFFFF_FFFF_FFFF_FFFF);
        sel2 = 1'b0; sel8 = 3'd0;
        tick();
        check("w8_word0", y2, 8'h5A);
        check("w64_word0", y8, d8[63:0]);
        check("w64_err", err8, 1'b0);
        iv2 = 1'b0; iv8 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
